// File: rtl/gate_analyzer.sv
// Sweeps all eight input combinations through an external 3-input gate,
// captures its truth table and classifies it against a set of known functions.
module gate_analyzer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iStart,
    input  logic       iY,
    output logic       oA,
    output logic       oB,
    output logic       oC,
    output logic       oBusy,
    output logic       oDone,
    output logic [7:0] oTabla,
    output logic [3:0] oCodigo,
    output logic       oValido
);
    // state    | meaning
    // IDLE     | waiting for iStart, stimulus held at 000
    // APPLY    | driving vector k for SETTLE cycles, capturing iY on the last one
    // CLASSIFY | capture complete, publishing table and code on exit
    // DONE     | one-cycle completion pulse
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        APPLY    = 2'd1,
        CLASSIFY = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [7:0] LAST = 8'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cap_q, cap_d;
    logic [2:0]  abc_q, abc_d;
    logic [7:0]  tabla_q, tabla_d;
    logic [3:0]  codigo_q, codigo_d;
    logic        valido_q, valido_d;
    logic [3:0]  class_code;

    function automatic logic [3:0] classify(input logic [7:0] t);
        case (t)
            8'h80:   classify = 4'd1;
            8'h7F:   classify = 4'd2;
            8'hFE:   classify = 4'd3;
            8'h01:   classify = 4'd4;
            8'h0F:   classify = 4'd5;
            8'h33:   classify = 4'd6;
            8'h96:   classify = 4'd7;
            8'h69:   classify = 4'd8;
            8'h00:   classify = 4'd9;
            8'hFF:   classify = 4'd10;
            default: classify = 4'd0;
        endcase
    endfunction

    assign class_code = classify(cap_q);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        abc_d    = abc_q;
        tabla_d  = tabla_q;
        codigo_d = codigo_q;
        valido_d = valido_q;
        case (state_q)
            IDLE: begin
                abc_d = 3'b000;
                if (iStart) begin
                    state_d = APPLY;
                    k_d     = 3'd0;
                    cnt_d   = 8'd0;
                    cap_d   = 8'h00;
                end
            end
            APPLY: begin
                if (cnt_q == LAST) begin
                    cap_d[k_q] = iY;
                    cnt_d      = 8'd0;
                    k_d        = k_q + 3'd1;
                    // The stimulus register is loaded with the next vector on the
                    // capture edge so each vector is held for exactly SETTLE cycles.
                    if (k_q == 3'd7) begin
                        state_d = CLASSIFY;
                        abc_d   = 3'b000;
                    end else begin
                        abc_d = k_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CLASSIFY: begin
                tabla_d  = cap_q;
                codigo_d = class_code;
                valido_d = (class_code != 4'd0);
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q  <= IDLE;
            k_q      <= 3'd0;
            cnt_q    <= 8'd0;
            cap_q    <= 8'h00;
            abc_q    <= 3'b000;
            tabla_q  <= 8'h00;
            codigo_q <= 4'd0;
            valido_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
            abc_q    <= abc_d;
            tabla_q  <= tabla_d;
            codigo_q <= codigo_d;
            valido_q <= valido_d;
        end
    end

    assign oA      = abc_q[2];
    assign oB      = abc_q[1];
    assign oC      = abc_q[0];
    assign oBusy   = (state_q != IDLE);
    assign oDone   = (state_q == DONE);
    assign oTabla  = tabla_q;
    assign oCodigo = codigo_q;
    assign oValido = valido_q;

endmodule

// File: tb/tb_gate_analyzer.sv
// Bench for gate_analyzer: one instance with SETTLE=2 for table/random sweeps
// and reset abort, one with SETTLE=1 for back-to-back and ignored-start cases.
module tb_gate_analyzer;
    localparam int S0 = 2;
    localparam int S1 = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start0, y0, a0, b0, c0, busy0, done0, valid0;
    logic [7:0] tabla0;
    logic [3:0] code0;
    logic [7:0] drv0;

    logic       start1, y1, a1, b1, c1, busy1, done1, valid1;
    logic [7:0] tabla1;
    logic [3:0] code1;
    logic [7:0] drv1;

    // The gate under test is modelled as a truth table indexed by {A,B,C}.
    assign y0 = drv0[{a0, b0, c0}];
    assign y1 = drv1[{a1, b1, c1}];

    gate_analyzer #(.SETTLE(S0)) dut0 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start0), .iY(y0),
        .oA(a0), .oB(b0), .oC(c0), .oBusy(busy0), .oDone(done0),
        .oTabla(tabla0), .oCodigo(code0), .oValido(valid0)
    );

    gate_analyzer #(.SETTLE(S1)) dut1 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start1), .iY(y1),
        .oA(a1), .oB(b1), .oC(c1), .oBusy(busy1), .oDone(done1),
        .oTabla(tabla1), .oCodigo(code1), .oValido(valid1)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string nm, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    typedef enum int {G_AND3, G_NAND3, G_OR3, G_NOR3, G_NOTA, G_NOTB, G_XOR3,
                      G_XNOR3, G_ZERO, G_ONE, G_AB, G_NOTC, G_AORB} gate_e;

    function automatic logic gate_eval(input gate_e g, input logic a, input logic b, input logic c);
        case (g)
            G_AND3:  return a & b & c;
            G_NAND3: return ~(a & b & c);
            G_OR3:   return a | b | c;
            G_NOR3:  return ~(a | b | c);
            G_NOTA:  return ~a;
            G_NOTB:  return ~b;
            G_XOR3:  return a ^ b ^ c;
            G_XNOR3: return ~(a ^ b ^ c);
            G_ZERO:  return 1'b0;
            G_ONE:   return 1'b1;
            G_AB:    return a & b;
            G_NOTC:  return ~c;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [7:0] gate_table(input gate_e g);
        logic [7:0] t;
        for (int k = 0; k < 8; k++) begin
            logic [2:0] kv;
            kv   = 3'(k);
            t[k] = gate_eval(g, kv[2], kv[1], kv[0]);
        end
        return t;
    endfunction

    // Reference classifier: position in the list of known tables, plus one.
    logic [7:0] known [10] = '{8'h80, 8'h7F, 8'hFE, 8'h01, 8'h0F,
                               8'h33, 8'h96, 8'h69, 8'h00, 8'hFF};

    function automatic int ref_code(input logic [7:0] t);
        for (int i = 0; i < 10; i++)
            if (known[i] == t) return i + 1;
        return 0;
    endfunction

    typedef struct {
        string      name;
        gate_e      gate;
        logic [7:0] exp_tabla;
        logic [3:0] exp_code;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [13];
    logic [7:0] model_tabla = 8'h00;

    // One full sweep on dut0, checking latency, stimulus order, busy and result hold.
    task automatic sweep0(input logic [7:0] tt, input string nm,
                          output logic [7:0] t, output logic [3:0] c, output logic v);
        int n, lat, order_err, hold_err, busy_err;
        drv0 = tt;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        n = 0; lat = -1; order_err = 0; hold_err = 0; busy_err = 0;
        while (lat < 0 && n < 200) begin
            @(negedge clk);
            n++;
            if (busy0 !== 1'b1) busy_err++;
            if (done0 === 1'b1) lat = n;
            else begin
                if (tabla0 !== model_tabla) hold_err++;
                if (n <= 8 * S0 && {a0, b0, c0} !== 3'((n - 1) / S0)) order_err++;
            end
        end
        check({nm, "_latency"}, lat, 8 * S0 + 2);
        check({nm, "_stim_order"}, order_err, 0);
        check({nm, "_hold_prev"}, hold_err, 0);
        check({nm, "_busy"}, busy_err, 0);
        t = tabla0; c = code0; v = valid0;
        @(negedge clk);
        check({nm, "_idle_after"}, {busy0, done0}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t;
        logic [3:0] c;
        logic       v;
        int         n, pulses, found;
        int         dt [3];

        vecs[0]  = '{"and3",  G_AND3,  8'h80, 4'd1,  1'b1};
        vecs[1]  = '{"nand3", G_NAND3, 8'h7F, 4'd2,  1'b1};
        vecs[2]  = '{"or3",   G_OR3,   8'hFE, 4'd3,  1'b1};
        vecs[3]  = '{"nor3",  G_NOR3,  8'h01, 4'd4,  1'b1};
        vecs[4]  = '{"nota",  G_NOTA,  8'h0F, 4'd5,  1'b1};
        vecs[5]  = '{"xor3",  G_XOR3,  8'h96, 4'd7,  1'b1};
        vecs[6]  = '{"notb",  G_NOTB,  8'h33, 4'd6,  1'b1};
        vecs[7]  = '{"xnor3", G_XNOR3, 8'h69, 4'd8,  1'b1};
        vecs[8]  = '{"zero",  G_ZERO,  8'h00, 4'd9,  1'b1};
        vecs[9]  = '{"ab",    G_AB,    8'hC0, 4'd0,  1'b0};
        vecs[10] = '{"one",   G_ONE,   8'hFF, 4'd10, 1'b1};
        vecs[11] = '{"notc",  G_NOTC,  8'h55, 4'd0,  1'b0};
        vecs[12] = '{"aorb",  G_AORB,  8'hFC, 4'd0,  1'b0};

        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; drv0 = 8'h00; drv1 = 8'h00;
        #2;
        check("reset_outs0", {a0, b0, c0, busy0, done0, tabla0, code0, valid0}, 0);
        check("reset_outs1", {a1, b1, c1, busy1, done1, tabla1, code1, valid1}, 0);
        #10 rst_n = 1'b1;

        foreach (vecs[i]) begin
            sweep0(gate_table(vecs[i].gate), vecs[i].name, t, c, v);
            check({vecs[i].name, "_tabla"}, t, vecs[i].exp_tabla);
            check({vecs[i].name, "_code"}, c, vecs[i].exp_code);
            check({vecs[i].name, "_valid"}, v, vecs[i].exp_valid);
            model_tabla = vecs[i].exp_tabla;
        end

        for (int r = 0; r < 12; r++) begin
            logic [7:0] tt;
            int         ec;
            tt = ($urandom_range(0, 1) == 1) ? known[$urandom_range(0, 9)] : 8'($urandom);
            ec = ref_code(tt);
            sweep0(tt, "rand", t, c, v);
            check("rand_tabla", t, tt);
            check("rand_code", c, ec);
            check("rand_valid", v, (ec != 0) ? 1 : 0);
            model_tabla = tt;
        end

        // Reset in the middle of vector 4 aborts the sweep.
        drv0 = gate_table(G_OR3);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        n = 0;
        while ({a0, b0, c0} !== 3'd4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_k4", {a0, b0, c0}, 4);
        #2 rst_n = 1'b0;
        #1;
        check("abort_reset_outs", {a0, b0, c0, busy0, done0, tabla0, code0, valid0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done0 === 1'b1 || busy0 === 1'b1) pulses++;
        end
        check("abort_no_done", pulses, 0);
        check("abort_tabla", tabla0, 0);
        model_tabla = 8'h00;
        sweep0(gate_table(G_AND3), "post_reset", t, c, v);
        check("post_reset_tabla", t, 8'h80);
        check("post_reset_code", c, 1);
        model_tabla = 8'h80;

        // dut1: start held high for three back-to-back sweeps.
        drv1 = gate_table(G_XOR3);
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        n = 0; found = 0; pulses = 0;
        while (found < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (n <= 8 && {a1, b1, c1} !== 3'(n - 1)) pulses++;
            if (done1 === 1'b1) begin
                dt[found] = n;
                found++;
            end
        end
        start1 = 1'b0;
        check("b2b_found", found, 3);
        check("b2b_stim_order", pulses, 0);
        check("b2b_first_done", dt[0], 8 * S1 + 2);
        check("b2b_gap1", dt[1] - dt[0], 11);
        check("b2b_gap2", dt[2] - dt[1], 11);
        check("b2b_tabla", tabla1, 8'h96);
        check("b2b_code", code1, 7);
        @(negedge clk);

        // dut1: extra start pulses mid-sweep are ignored.
        drv1 = gate_table(G_NOTB);
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        n = 0; found = -1;
        while (found < 0 && n < 100) begin
            @(negedge clk);
            n++;
            start1 = (n == 3 || n == 6) ? 1'b1 : 1'b0;
            if (done1 === 1'b1) found = n;
        end
        start1 = 1'b0;
        check("extra_start_done", found, 8 * S1 + 2);
        check("extra_start_tabla", tabla1, 8'h33);
        check("extra_start_code", code1, 6);
        pulses = 0;
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (busy1 === 1'b1) pulses++;
        end
        check("extra_start_not_queued", pulses, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/gate_analyzer.md
GATE_ANALYZER -- requirements
Module: analizador_compuertas

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, meaning clock cycles each input vector is held before iY is sampled; legal range 1..255.
REQ-002 iClk  input  1  single system clock; all state changes on rising edge.
REQ-003 iRst_n  input  1  asynchronous, active-low reset.
REQ-004 iStart  input  1  request a full truth-table sweep; sampled only in IDLE.
REQ-005 iY  input  1  response of the 3-input gate under test, synchronous to iClk.
REQ-006 oA, oB, oC  output  1 each  stimulus driven to the gate under test.
REQ-007 oBusy  output  1  high from start acceptance until the end of the DONE cycle.
REQ-008 oDone  output  1  one-cycle pulse when a new result is published.
REQ-009 oTabla  output  8  captured truth table; bit k = iY for vector k.
REQ-010 oCodigo  output  4  classification of oTabla.
REQ-011 oValido  output  1  high when oCodigo != 0.

Function
REQ-012 The block SHALL implement FSM states IDLE, APPLY, CLASSIFY, DONE.
REQ-013 IDLE: oA=oB=oC=0, oBusy=0; iStart=1 at a rising edge -> APPLY with vector index k=0, settle counter=0, internal capture register cleared.
REQ-014 APPLY: oA=k[2], oB=k[1], oC=k[0], oBusy=1; the settle counter SHALL increment each cycle, from 0 up to SETTLE-1.
REQ-015 On the edge where the counter equals SETTLE-1, iY SHALL be captured into internal bit k, the counter SHALL reset to 0 and k SHALL increment; after capturing k=7 the FSM SHALL go to CLASSIFY.
REQ-016 Each vector SHALL therefore be driven for exactly SETTLE cycles; vectors SHALL be applied in order 0..7 with no gap cycles.
REQ-017 CLASSIFY, one cycle: oTabla and oCodigo SHALL be loaded from the capture register on the exiting edge; next state DONE.
REQ-018 DONE, one cycle: oDone=1, oBusy=1; next state IDLE unconditionally.
REQ-019 Latency: with start accepted at edge E0, oDone SHALL be high in the cycle following edge E0+8*SETTLE+1.
REQ-020 Classification by exact match of oTabla: 0x80->1 AND3, 0x7F->2 NAND3, 0xFE->3 OR3, 0x01->4 NOR3, 0x0F->5 NOT A, 0x33->6 NOT B, 0x96->7 XOR3, 0x69->8 XNOR3, 0x00->9 const 0, 0xFF->10 const 1, any other value->0 unknown.
REQ-021 oTabla, oCodigo and oValido SHALL hold the previous result throughout a new sweep; they change only on the CLASSIFY exit edge.
REQ-022 iStart while not in IDLE SHALL be ignored; it is neither queued nor counted.
REQ-023 With iStart held high continuously, sweeps SHALL repeat with exactly one IDLE cycle between DONE and the next APPLY.
REQ-024 oA, oB and oC SHALL be registered outputs, free of glitches.

Reset
REQ-025 While iRst_n=0, asynchronously: state=IDLE, k=0, settle counter=0, capture register=0, oA=oB=oC=0, oBusy=0, oDone=0, oTabla=0x00, oCodigo=0, oValido=0.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep with no oDone pulse and no publication of the partial table.
REQ-027 After reset release, the first edge with iStart=1 SHALL start a sweep normally.

Verification
REQ-028 SETTLE=2, iY driven as A&B&C of oA/oB/oC, single iStart pulse -> oDone 18 cycles after start edge, oTabla=0x80, oCodigo=1, oValido=1.
REQ-029 iY=A^B^C -> oTabla=0x96, oCodigo=7; then iY=~B -> second sweep gives oTabla=0x33, oCodigo=6, and oTabla stays 0x96 until the second CLASSIFY.
REQ-030 iY=A&B (2-input only) -> oTabla=0xC0, oCodigo=0, oValido=0; iY tied 1 -> 0xFF, oCodigo=10.
REQ-031 iRst_n pulsed low during vector k=4 -> all outputs at reset values immediately, no oDone, oTabla=0x00; a new iStart completes correctly.
REQ-032 iStart held high for 3 sweeps with SETTLE=1 -> oDone pulses spaced 11 cycles apart; extra iStart pulses mid-sweep have no effect; oA/oB/oC step 0..7, each held SETTLE cycles.
